gaussian_line_buffer: RTL

GAUSSIAN_LINE_BUFFER -- requirements
Module: gaussian_line_buffer

---
 rtl/gaussian_line_buffer_if.sv | 26 ++
 rtl/gaussian_line_buffer.sv | 102 ++++++++++
 2 files changed

// File: rtl/gaussian_line_buffer_if.sv
// Pixel-stream and window-column bundle for gaussian_line_buffer.
// The master drives the raster stream; the slave returns 5-row window columns.
interface gaussian_line_buffer_if #(
  parameter int unsigned PIXEL_WIDTH = 8
);
  logic                   enable;
  logic                   valid_in;
  logic                   sof;
  logic [PIXEL_WIDTH-1:0] pixel_in;
  logic [PIXEL_WIDTH-1:0] win_row_0;
  logic [PIXEL_WIDTH-1:0] win_row_1;
  logic [PIXEL_WIDTH-1:0] win_row_2;
  logic [PIXEL_WIDTH-1:0] win_row_3;
  logic [PIXEL_WIDTH-1:0] win_row_4;
  logic                   valid_out;

  modport master (
    output enable, valid_in, sof, pixel_in,
    input  win_row_0, win_row_1, win_row_2, win_row_3, win_row_4, valid_out
  );

  modport slave (
    input  enable, valid_in, sof, pixel_in,
    output win_row_0, win_row_1, win_row_2, win_row_3, win_row_4, valid_out
  );
endinterface

// File: rtl/gaussian_line_buffer.sv
// Four-line buffer producing one vertical 5-pixel column per accepted pixel.
// Define GAUSS_LB_TOP_REPLICATE_EN to emit windows from row 0 with line-0 replication on top.
module gaussian_line_buffer #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned IMG_WIDTH   = 640
) (
  input  logic                  clk,
  input  logic                  rst,
  gaussian_line_buffer_if.slave bus
);

  localparam int unsigned COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned LAST_COL = IMG_WIDTH - 1;

  logic [PIXEL_WIDTH-1:0] lb [0:3][0:IMG_WIDTH-1];

  logic [COL_W-1:0]       col_cnt;
  logic [2:0]             row_cnt;
  logic [PIXEL_WIDTH-1:0] win_q [0:4];
  logic                   valid_q;

  logic                   accept_c;
  logic [COL_W-1:0]       col_eff_c;
  logic [2:0]             row_eff_c;
  logic [COL_W-1:0]       col_nxt_c;
  logic [2:0]             row_nxt_c;
  logic [PIXEL_WIDTH-1:0] lb_rd_c [0:3];
  logic [PIXEL_WIDTH-1:0] win_d_c [0:4];
  logic                   valid_d_c;
`ifdef GAUSS_LB_TOP_REPLICATE_EN
  logic [PIXEL_WIDTH-1:0] line0_c;
`endif

  // sof forces the incoming pixel to row 0 / column 0 before anything else is derived
  always_comb begin
    accept_c  = bus.enable & bus.valid_in;
    col_eff_c = bus.sof ? '0 : col_cnt;
    row_eff_c = bus.sof ? 3'd0 : row_cnt;
    for (int k = 0; k < 4; k++) lb_rd_c[k] = lb[k][col_eff_c];

    if (col_eff_c == COL_W'(LAST_COL)) begin
      col_nxt_c = '0;
      row_nxt_c = (row_eff_c == 3'd4) ? 3'd4 : row_eff_c + 3'd1;
    end else begin
      col_nxt_c = col_eff_c + COL_W'(1);
      row_nxt_c = row_eff_c;
    end

    win_d_c[4] = bus.pixel_in;
    for (int k = 0; k < 4; k++) win_d_c[k] = lb_rd_c[3-k];
    valid_d_c = (row_eff_c == 3'd4);

`ifdef GAUSS_LB_TOP_REPLICATE_EN
    // Line 0 of the frame sits in LB(row-1); on row 0 it is the incoming pixel itself
    case (row_eff_c)
      3'd1:    line0_c = lb_rd_c[0];
      3'd2:    line0_c = lb_rd_c[1];
      3'd3:    line0_c = lb_rd_c[2];
      3'd4:    line0_c = lb_rd_c[3];
      default: line0_c = bus.pixel_in;
    endcase
    for (int k = 0; k < 4; k++) begin
      if (k + int'(row_eff_c) < 4) win_d_c[k] = line0_c;
    end
    valid_d_c = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= 3'd0;
      valid_q <= 1'b0;
      for (int k = 0; k < 5; k++) win_q[k] <= '0;
    end else if (bus.enable) begin
      if (bus.valid_in) begin
        col_cnt <= col_nxt_c;
        row_cnt <= row_nxt_c;
        valid_q <= valid_d_c;
        for (int k = 0; k < 5; k++) win_q[k] <= win_d_c[k];
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  // Line memories shift down one line per accepted pixel; never reset, stale data is masked
  always_ff @(posedge clk) begin
    if (!rst && accept_c) begin
      lb[0][col_eff_c] <= bus.pixel_in;
      for (int k = 1; k < 4; k++) lb[k][col_eff_c] <= lb_rd_c[k-1];
    end
  end

  assign bus.win_row_0 = win_q[0];
  assign bus.win_row_1 = win_q[1];
  assign bus.win_row_2 = win_q[2];
  assign bus.win_row_3 = win_q[3];
  assign bus.win_row_4 = win_q[4];
  assign bus.valid_out = valid_q;

endmodule
